// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU control unit.
//  - opcode values of the 4-bit instruction set
//  - ALUOp encodings driven towards the ALU
//  - control FSM state encoding
//  - opcode classification helpers used by the FSM and the output decode
package controle_multiciclo_pkg;

  // Opcodes. 10..14 are unassigned and decode as illegal.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_LDA = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDB = 4'd4;
  localparam logic [3:0] OP_STB = 4'd5;
  localparam logic [3:0] OP_LDC = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_AND = 4'd9;
  localparam logic [3:0] OP_HLT = 4'd15;

  // ALU function codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Memory loads into A or B
  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_LDB);
  endfunction

  // Memory stores from A or B
  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_STA) || (op == OP_STB);
  endfunction

  // Register-immediate ALU operations writing back to A
  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) || (op == OP_AND);
  endfunction

  // Every assigned opcode, HLT included
  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_AND) || (op == OP_HLT);
  endfunction

  // ALU function for the EXEC step; address and LDC paths use plain add
  function automatic logic [1:0] alu_code(input logic [3:0] op);
    logic [1:0] c;
    case (op)
      OP_SUB:  c = ALU_SUB;
      OP_OR:   c = ALU_OR;
      OP_AND:  c = ALU_AND;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit for the accumulator CPU (registers A/B).
// Sequences IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] over a single
// shared memory port using a req/ack handshake, with a watchdog on every
// memory request.
//
// Ports
//  clk, rst_n           clock, asynchronous active-low reset
//  run                  start level, looked at only in IDLE
//  instrucao            opcode field of the IR
//  zero                 A == 0 from the datapath (JMP condition)
//  mem_ack              memory completed the current request
//  mem_req, IorD        memory request and address select (0 PC, 1 imm/ALU)
//  MemRead, MemWrite    memory direction, valid with mem_req
//  IRWrite, PCWrite     IR / PC load strobes
//  PCSrc                0 PC+1, 1 immediate
//  ALUSrc, ALUOp        ALU operand select and function
//  RegWrite, RegDst     register write strobe, destination (0 A, 1 B)
//  MemtoReg             write-back from memory data
//  ill_op, bus_err      one-cycle error pulses
//  halted               high while halted
//
// Only the state and the timeout counter are registered; all outputs are
// decoded combinationally from the state and the current inputs, so an
// asynchronous reset drops every strobe immediately.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int ALUOP_W     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] instrucao,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCSrc,
  output logic                ALUSrc,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                ill_op,
  output logic                bus_err,
  output logic                halted
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0] w_op;
  logic       w_in_range;
  logic       w_legal;
  logic       w_is_hlt;
  logic       w_mem_phase;
  logic       w_timeout;

  // Wider opcode fields carry encodings beyond 15, which are all illegal.
  assign w_op       = 4'(instrucao);
  assign w_in_range = (32'(instrucao) < 32'd16);
  assign w_legal    = w_in_range && is_legal(w_op);
  assign w_is_hlt   = w_in_range && (w_op == OP_HLT);

  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);

  // Last allowed unacknowledged cycle; an ack in this same cycle still wins.
  assign w_timeout = w_mem_phase && !mem_ack && (r_cnt == CNT_LAST);

  // State register and request watchdog. The counter is cleared on every
  // entry to FETCH/MEM and counts waiting cycles while the request is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
          end
        end
        S_FETCH: begin
          if (mem_ack)        r_state <= S_DECODE;
          else if (w_timeout) r_state <= S_HALT;
          else                r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_DECODE: begin
          if (w_is_hlt) begin
            r_state <= S_HALT;
          end else if (!w_legal) begin
            // illegal opcode behaves as a NOP
            r_state <= S_FETCH;
            r_cnt   <= '0;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_load(w_op) || is_store(w_op)) begin
            r_state <= S_MEM;
            r_cnt   <= '0;
          end else if (w_op == OP_JMP) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (is_store(w_op)) begin
              r_state <= S_FETCH;
              r_cnt   <= '0;
            end else begin
              r_state <= S_WB;
            end
          end else if (w_timeout) begin
            r_state <= S_HALT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_cnt   <= '0;
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = '0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ill_op   = 1'b0;
    bus_err  = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        // IR and PC+1 are captured on the ack edge
        IRWrite = mem_ack;
        PCWrite = mem_ack;
        bus_err = w_timeout;
      end
      S_DECODE: begin
        ill_op = !w_legal;
      end
      S_EXEC: begin
        if (w_op == OP_JMP) begin
          PCWrite = zero;
          PCSrc   = 1'b1;
        end else begin
          ALUSrc = 1'b1;
          ALUOp  = ALUOP_W'(alu_code(w_op));
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemRead  = is_load(w_op);
        MemWrite = is_store(w_op);
        bus_err  = w_timeout;
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = is_load(w_op);
        RegDst   = (w_op == OP_LDB);
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo. For each instruction an expected cycle trace
// (output bundle plus the ack value to drive) is built from the instruction's
// phase list, then replayed cycle by cycle against the DUT.
module tb_controle_multiciclo;

  localparam int OPW = 4;
  localparam int T   = 16;
  localparam int AW  = 2;

  typedef struct packed {
    logic       req;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       pcw;
    logic       pcs;
    logic       alus;
    logic [1:0] aop;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       ill;
    logic       be;
    logic       hlt;
  } out_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           run = 1'b0;
  logic [OPW-1:0] instrucao = '0;
  logic           zero = 1'b0;
  logic           mem_ack = 1'b0;
  logic           mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrc;
  logic [AW-1:0]  ALUOp;
  logic           RegWrite, RegDst, MemtoReg, ill_op, bus_err, halted;
  out_t           obs;

  int n_tests = 0;
  int n_fail  = 0;

  out_t  q_exp[$];
  bit    q_ack[$];
  string q_tag[$];

  controle_multiciclo #(.OPCODE_W(OPW), .MEM_TIMEOUT(T), .ALUOP_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instrucao(instrucao), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ill_op(ill_op), .bus_err(bus_err), .halted(halted)
  );

  assign obs = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrc,
                ALUOp, RegWrite, RegDst, MemtoReg, ill_op, bus_err, halted};

  always #5 clk = ~clk;

  task automatic check(input string t, input out_t o, input out_t e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, o, e);
    end
  endtask

  task automatic push(input out_t e, input bit a, input string t);
    q_exp.push_back(e);
    q_ack.push_back(a);
    q_tag.push_back(t);
  endtask

  // One memory transaction that is acked after d wait cycles, or gives up
  // with bus_err on the T-th request cycle.
  task automatic mem_phase(input bit iord, input bit rd, input bit wr, input bit fetch,
                           input int d, input string t, output bit to);
    int   n;
    out_t e;
    to = (d + 1 > T);
    n  = to ? T : d + 1;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.req = 1'b1; e.iord = iord; e.mr = rd; e.mw = wr;
      if (i == n - 1 && to) e.be = 1'b1;
      if (i == n - 1 && !to && fetch) begin e.irw = 1'b1; e.pcw = 1'b1; end
      push(e, (i == d), t);
    end
  endtask

  task automatic push_halt(input int n);
    out_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.hlt = 1'b1;
      push(e, 1'($urandom_range(0, 1)), "halt");
    end
  endtask

  // Expected trace of one instruction; hlt set when it ends in HALT.
  task automatic gen_instr(input logic [3:0] op, input bit z, input int dF, input int dM,
                           output bit hlt);
    out_t  e;
    bit    to;
    bit    legal, ld, st;
    string t;
    hlt   = 1'b0;
    legal = (op <= 4'd9) || (op == 4'd15);
    ld    = (op == 4'd2) || (op == 4'd4);
    st    = (op == 4'd3) || (op == 4'd5);
    t = $sformatf("op%0d_fetch", op);
    mem_phase(1'b0, 1'b1, 1'b0, 1'b1, dF, t, to);
    if (to) begin hlt = 1'b1; push_halt(3); return; end
    e = '0; e.ill = !legal;
    push(e, 1'($urandom_range(0, 1)), $sformatf("op%0d_decode", op));
    if (op == 4'd15) begin hlt = 1'b1; push_halt(3); return; end
    if (!legal) return;
    e = '0;
    case (op)
      4'd1: begin e.alus = 1'b1; e.aop = 2'b01; end
      4'd8: begin e.alus = 1'b1; e.aop = 2'b10; end
      4'd9: begin e.alus = 1'b1; e.aop = 2'b11; end
      4'd7: begin e.pcw = z; e.pcs = 1'b1; end
      default: e.alus = 1'b1;
    endcase
    push(e, 1'($urandom_range(0, 1)), $sformatf("op%0d_exec", op));
    if (op == 4'd7) return;
    if (ld || st) begin
      mem_phase(1'b1, ld, st, 1'b0, dM, $sformatf("op%0d_mem", op), to);
      if (to) begin hlt = 1'b1; push_halt(3); return; end
      if (st) return;
    end
    e = '0; e.rw = 1'b1; e.m2r = ld; e.rd = (op == 4'd4);
    push(e, 1'($urandom_range(0, 1)), $sformatf("op%0d_wb", op));
  endtask

  // Replay the queued trace; opcode/zero change in the first (FETCH) cycle.
  task automatic run_queue(input logic [3:0] op, input bit z);
    out_t  e;
    bit    a;
    string t;
    bit    first;
    first = 1'b1;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      a = q_ack.pop_front();
      t = q_tag.pop_front();
      @(posedge clk); #1;
      mem_ack = a;
      run = 1'($urandom_range(0, 1));
      if (first) begin instrucao = OPW'(op); zero = z; first = 1'b0; end
      @(negedge clk);
      check(t, obs, e);
    end
  endtask

  task automatic do_instr(input logic [3:0] op, input bit z, input int dF, input int dM,
                          output bit hlt);
    gen_instr(op, z, dF, dM, hlt);
    run_queue(op, z);
  endtask

  // Reset asserted mid-cycle, held, released; one IDLE cycle with run=0,
  // then run=1 so the next edge enters FETCH.
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; run = 1'b1; mem_ack = 1'b1;
    #1 check("rst_async", obs, '0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold", obs, '0);
    end
    rst_n = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle", obs, '0);
    run = 1'b1;
  endtask

  function automatic int rnd_delay();
    return ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 20))
                                        : int'($urandom_range(0, 3));
  endfunction

  initial begin
    bit hlt;
    logic [3:0] op;
    // directed program
    do_reset();
    do_instr(4'd0,  1'b0, 0, 0, hlt);   // ADD, zero-wait
    do_instr(4'd4,  1'b0, 1, 3, hlt);   // LDB, ack delayed 3 in MEM
    do_instr(4'd7,  1'b1, 0, 0, hlt);   // JMP taken
    do_instr(4'd7,  1'b0, 0, 0, hlt);   // JMP not taken
    do_instr(4'd10, 1'b0, 0, 0, hlt);   // illegal
    do_instr(4'd15 - 4'd6, 1'b0, 2, 0, hlt); // AND
    do_instr(4'd3,  1'b0, 0, 15, hlt);  // STA, ack on the last allowed cycle
    do_instr(4'd3,  1'b0, 0, 100, hlt); // STA, memory never answers
    do_reset();
    do_instr(4'd6,  1'b0, 0, 0, hlt);   // LDC
    do_instr(4'd15, 1'b0, 0, 0, hlt);   // HLT
    do_reset();
    do_instr(4'd2,  1'b0, 100, 0, hlt); // fetch timeout
    // random programs
    for (int p = 0; p < 16; p++) begin
      do_reset();
      for (int k = 0; k < 25; k++) begin
        op = 4'($urandom_range(0, 15));
        do_instr(op, 1'($urandom_range(0, 1)), rnd_delay(), rnd_delay(), hlt);
        if (hlt) break;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
